tmds_multi_encoder: RTL
=======================

// Module: tmds_multi_encoder
// PURPOSE
//  NUM_CH-lane pipelined TMDS/HDMI symbol encoder; one 10-bit symbol per lane per clk.
//  Supports video (8b/10b DVI with running disparity), control, TERC4 data-island and guard-band modes.
//  Sits between the timing/packet mux and the per-lane 10:1 serialisers; all lanes share one mode.
// PARAMETERS
//  NUM_CH  3  lane count (>=1); lane i uses data[8i+:8], ctrl[2i+:2], aux[4i+:4], tmds[10i+:10]
//  DISP_W  5  signed running-disparity width per lane (>=5)
// PORTS
//  clk       in   1         clock
//  rst       in   1         reset, synchronous, active-high
//  in_valid  in   1         input symbol qualifier
//  mode      in   2         0 CTRL, 1 VIDEO, 2 ISLAND (TERC4), 3 GUARD
//  gb_island in   1         GUARD only: 0 video guard band, 1 data-island guard band
//  data      in   8*NUM_CH  video pixel bytes
//  ctrl      in   2*NUM_CH  control bits {c1,c0} per lane
//  aux       in   4*NUM_CH  TERC4 nibble per lane
//  out_valid out  1         tmds qualifier
//  tmds      out  10*NUM_CH encoded symbols, bit 0 transmitted first
// BEHAVIOUR
//  Latency fixed 2 clk: in_valid/inputs at edge N -> out_valid/tmds at edge N+2. No back-pressure.
//  Stage 1 (per lane): N1=popcount(data); use XNOR if N1>4 or (N1==4 and data[0]==0), else XOR;
//   q_m[0]=d[0], q_m[k]=q_m[k-1] (X)OR d[k], q_m[8]=1 for XOR, 0 for XNOR. Register q_m, mode, ctrl, aux, gb_island, valid.
//  Stage 2 VIDEO, cnt = lane disparity, n1/n0 = ones/zeros of q_m[7:0], diff=n1-n0 (signed, DISP_W):
//   cnt==0 or diff==0: tmds={~q_m8,q_m8,q_m8?q_m[7:0]:~q_m[7:0]}; cnt+= q_m8 ? diff : -diff
//   (cnt>0 & diff>0) or (cnt<0 & diff<0): tmds={1,q_m8,~q_m[7:0]}; cnt+= 2*q_m8 - diff
//   else: tmds={0,q_m8,q_m[7:0]}; cnt+= diff - 2*(~q_m8)
//  CTRL: {c1,c0} 00->0x354, 01->0x0AB, 10->0x154, 11->0x2AB.
//  ISLAND: tmds=TERC4[aux] (HDMI table, q_out[9:0]: 0->0x29C 1->0x263 2->0x2E4 3->0x2E2 4->0x171
//   5->0x11E 6->0x18E 7->0x13C 8->0x2CC 9->0x139 A->0x19C B->0x2C7 C->0x28E D->0x271 E->0x163 F->0x2C3).
//  GUARD gb_island=0: even lanes 0x2CC, odd lanes 0x133. gb_island=1: lane0 TERC4[aux0], others 0x133.
//  cnt cleared to 0 on any valid non-VIDEO symbol; updated only on valid VIDEO symbols.
//  Stage-2 valid=0: tmds and cnt hold, out_valid=0.
//  Mode change takes effect on that symbol; VIDEO after any non-VIDEO starts with cnt=0.
//  Reset: out_valid=0, all tmds=0x354, all cnt=0, pipeline valids=0; a reset mid-stream discards both
//   in-flight symbols; first post-reset output 2 clk after first in_valid.
//  Disparity arithmetic signed DISP_W, no saturation (|cnt|<=10 by construction; DISP_W>=5 sufficient).
// STRUCTURE
//  tmds_pkg: mode_e enum, CTRL_CODE[4], TERC4_LUT[16], GB_VIDEO_EVEN/ODD, GB_ISLAND constants.
//  Sub-module tmds_lane_encoder (one lane, both stages, own cnt), generate-instantiated NUM_CH times;
//   top holds shared valid/mode pipeline and lane slicing.
// TESTING
//  VIDEO data=0x00 x3 from reset, lane0 -> tmds 0x100, 0x3FF, 0x100; cnt -8, 2, -6.
//  CTRL sweep ctrl=00/01/10/11 valid back-to-back -> 0x354/0x0AB/0x154/0x2AB, out_valid at edge+2.
//  ISLAND aux 0..F on all lanes -> TERC4 table values; then VIDEO 0x00 -> 0x100 (cnt restarted at 0).
//  GUARD gb_island=0 NUM_CH=3 -> {0x2CC,0x133,0x2CC}; gb_island=1 aux0=0xC -> lane0 0x28E, lanes1-2 0x133.
//  in_valid gaps mid-VIDEO stream -> tmds/cnt frozen during gap, sequence matches gapless golden model.
//  rst asserted with 2 symbols in flight -> next clk out_valid=0, tmds=0x354; 10k random VIDEO bytes
//   vs reference model, |cnt|<=10, decode round-trip exact.

Source files
------------

// File: rtl/tmds_pkg.sv
// Shared definitions for the TMDS multi-lane encoder.
//   mode_e        : lane mode shared by all lanes
//   CTRL_CODE     : control-period symbols indexed by {c1,c0}
//   TERC4_LUT     : HDMI TERC4 symbols indexed by the 4-bit nibble
//   GB_*          : guard-band symbols
//   tmds_qm       : DVI transition-minimising first stage (9-bit q_m)
package tmds_pkg;

    typedef enum logic [1:0] {
        MODE_CTRL   = 2'd0,
        MODE_VIDEO  = 2'd1,
        MODE_ISLAND = 2'd2,
        MODE_GUARD  = 2'd3
    } mode_e;

    localparam logic [9:0] CTRL_CODE [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

    localparam logic [9:0] TERC4_LUT [16] = '{
        10'h29C, 10'h263, 10'h2E4, 10'h2E2, 10'h171, 10'h11E, 10'h18E, 10'h13C,
        10'h2CC, 10'h139, 10'h19C, 10'h2C7, 10'h28E, 10'h271, 10'h163, 10'h2C3
    };

    localparam logic [9:0] GB_VIDEO_EVEN = 10'h2CC;
    localparam logic [9:0] GB_VIDEO_ODD  = 10'h133;
    localparam logic [9:0] GB_ISLAND     = 10'h133;

    // q_m[8] = 1 marks the XOR chain, 0 the XNOR chain.
    function automatic logic [8:0] tmds_qm(input logic [7:0] d);
        logic [3:0] ones;
        logic       use_xnor;
        logic [8:0] q;
        ones     = 4'($countones(d));
        use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !d[0]);
        q        = '0;
        q[0]     = d[0];
        for (int k = 1; k < 8; k++) begin
            q[k] = use_xnor ? ~(q[k-1] ^ d[k]) : (q[k-1] ^ d[k]);
        end
        q[8] = ~use_xnor;
        return q;
    endfunction

endpackage

// File: rtl/tmds_lane_encoder.sv
// One TMDS lane: stage-1 q_m register plus stage-2 symbol selection with
// the lane's own running disparity.
//   clk, rst        : clock, synchronous active-high reset
//   in_valid        : input qualifier (enables the stage-1 capture)
//   data/ctrl/aux   : this lane's pixel byte, control pair, TERC4 nibble
//   s1_valid/mode/gb: stage-1 shared qualifiers from the top
//   tmds            : registered 10-bit symbol
module tmds_lane_encoder
    import tmds_pkg::*;
#(
    parameter int LANE   = 0,
    parameter int DISP_W = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] data,
    input  logic [1:0] ctrl,
    input  logic [3:0] aux,
    input  logic       s1_valid,
    input  logic [1:0] s1_mode,
    input  logic       s1_gb_island,
    output logic [9:0] tmds
);

    localparam logic signed [DISP_W-1:0] S_ZERO  = '0;
    localparam logic signed [DISP_W-1:0] S_TWO   = DISP_W'(2);
    localparam logic signed [DISP_W-1:0] S_EIGHT = DISP_W'(8);

    logic [8:0] q_m;
    logic [1:0] ctrl_q;
    logic [3:0] aux_q;

    logic signed [DISP_W-1:0] cnt;
    logic signed [DISP_W-1:0] n1;
    logic signed [DISP_W-1:0] diff;
    logic signed [DISP_W-1:0] cnt_vid;
    logic [9:0]               sym_vid;
    logic [9:0]               sym_other;

    // Stage 1: only captured on valid symbols so idle cycles do not toggle.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_m    <= '0;
            ctrl_q <= '0;
            aux_q  <= '0;
        end else if (in_valid) begin
            q_m    <= tmds_qm(data);
            ctrl_q <= ctrl;
            aux_q  <= aux;
        end
    end

    // diff = ones - zeros of q_m[7:0] = 2*ones - 8
    always_comb begin
        n1   = DISP_W'($countones(q_m[7:0]));
        diff = (n1 <<< 1) - S_EIGHT;
    end

    always_comb begin
        sym_vid = '0;
        cnt_vid = cnt;
        if ((cnt == S_ZERO) || (diff == S_ZERO)) begin
            sym_vid = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]};
            cnt_vid = q_m[8] ? (cnt + diff) : (cnt - diff);
        end else if (((cnt > S_ZERO) && (diff > S_ZERO)) ||
                     ((cnt < S_ZERO) && (diff < S_ZERO))) begin
            sym_vid = {1'b1, q_m[8], ~q_m[7:0]};
            cnt_vid = cnt + (q_m[8] ? S_TWO : S_ZERO) - diff;
        end else begin
            sym_vid = {1'b0, q_m[8], q_m[7:0]};
            cnt_vid = cnt + diff - (q_m[8] ? S_ZERO : S_TWO);
        end
    end

    always_comb begin
        sym_other = CTRL_CODE[ctrl_q];
        case (mode_e'(s1_mode))
            MODE_ISLAND: sym_other = TERC4_LUT[aux_q];
            MODE_GUARD: begin
                if (s1_gb_island)
                    sym_other = (LANE == 0) ? TERC4_LUT[aux_q] : GB_ISLAND;
                else
                    sym_other = ((LANE % 2) == 0) ? GB_VIDEO_EVEN : GB_VIDEO_ODD;
            end
            default: ;
        endcase
    end

    // Stage 2: symbol and disparity hold while the stage is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmds <= CTRL_CODE[0];
            cnt  <= '0;
        end else if (s1_valid) begin
            if (mode_e'(s1_mode) == MODE_VIDEO) begin
                tmds <= sym_vid;
                cnt  <= cnt_vid;
            end else begin
                tmds <= sym_other;
                cnt  <= '0;
            end
        end
    end

endmodule

// File: rtl/tmds_multi_encoder.sv
// NUM_CH-lane pipelined TMDS/HDMI encoder, 2-clock latency, one symbol per
// lane per clock, all lanes in the same mode.
//   clk, rst  : clock, synchronous active-high reset
//   in_valid  : input qualifier
//   mode      : 0 CTRL, 1 VIDEO, 2 ISLAND, 3 GUARD
//   gb_island : GUARD flavour, 0 video guard band, 1 data-island guard band
//   data      : 8 bits per lane, ctrl: 2 bits per lane, aux: 4 bits per lane
//   out_valid : output qualifier
//   tmds      : 10 bits per lane, bit 0 sent first
module tmds_multi_encoder
    import tmds_pkg::*;
#(
    parameter int NUM_CH = 3,
    parameter int DISP_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [1:0]            mode,
    input  logic                  gb_island,
    input  logic [8*NUM_CH-1:0]   data,
    input  logic [2*NUM_CH-1:0]   ctrl,
    input  logic [4*NUM_CH-1:0]   aux,
    output logic                  out_valid,
    output logic [10*NUM_CH-1:0]  tmds
);

    logic       s1_valid;
    logic [1:0] s1_mode;
    logic       s1_gb_island;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid     <= 1'b0;
            s1_mode      <= MODE_CTRL;
            s1_gb_island <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (in_valid) begin
                s1_mode      <= mode;
                s1_gb_island <= gb_island;
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
        tmds_lane_encoder #(
            .LANE   (i),
            .DISP_W (DISP_W)
        ) u_lane (
            .clk          (clk),
            .rst          (rst),
            .in_valid     (in_valid),
            .data         (data[8*i +: 8]),
            .ctrl         (ctrl[2*i +: 2]),
            .aux          (aux[4*i +: 4]),
            .s1_valid     (s1_valid),
            .s1_mode      (s1_mode),
            .s1_gb_island (s1_gb_island),
            .tmds         (tmds[10*i +: 10])
        );
    end

endmodule
